// File: rtl/inst_axi_responder.sv
// Instruction-fetch responder: turns SRAM-like fetch requests into single-beat
// AXI4 reads and returns the data in request order.
module inst_axi_responder #(
  parameter int         MAX_OUTSTANDING = 4,
  parameter logic [3:0] ARID            = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  output logic        inst_data_err,
  output logic        idle,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        proto_err
);

  localparam logic [3:0] MAX_CNT_C = 4'(MAX_OUTSTANDING);

  logic        arvalid_r;
  logic [31:0] araddr_r;
  logic [3:0]  arcache_r;
  logic [3:0]  cnt_r;
  logic        data_ok_r;
  logic [31:0] rdata_r;
  logic        data_err_r;
  logic        proto_err_r;

  logic        slot_free_s;
  logic        r_hs_s;
  logic        r_take_s;
  logic        accept_s;
  logic        proto_hit_s;
  logic [3:0]  cnt_nxt_s;

  // Single ID and in-order return make rid and the OKAY/EXOKAY bit irrelevant.
  logic        unused_s;
  assign unused_s = ^{rid, rresp[0]};

  // Accept decision, R-beat classification and next outstanding count.
  always_comb begin
    slot_free_s = 1'b0;
    r_hs_s      = 1'b0;
    r_take_s    = 1'b0;
    accept_s    = 1'b0;
    proto_hit_s = 1'b0;
    cnt_nxt_s   = cnt_r;
    if (!arvalid_r || arready) begin
      slot_free_s = 1'b1;
    end else begin
      slot_free_s = 1'b0;
    end
    r_hs_s      = rvalid && !reset;
    r_take_s    = r_hs_s && (cnt_r != 4'd0);
    // A beat retired this cycle frees a slot for a request in the same cycle.
    accept_s    = !reset && inst_req && slot_free_s && ((cnt_r < MAX_CNT_C) || r_take_s);
    proto_hit_s = r_hs_s && ((cnt_r == 4'd0) || !rlast);
    case ({accept_s, r_take_s})
      2'b10:   cnt_nxt_s = cnt_r + 4'd1;
      2'b01:   cnt_nxt_s = cnt_r - 4'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // AR register, outstanding counter, response register and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_r   <= 1'b0;
      araddr_r    <= 32'd0;
      arcache_r   <= 4'd0;
      cnt_r       <= 4'd0;
      data_ok_r   <= 1'b0;
      rdata_r     <= 32'd0;
      data_err_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= inst_addr;
        arcache_r <= inst_cache ? 4'b1111 : 4'b0000;
      end else if (arvalid_r && arready) begin
        arvalid_r <= 1'b0;
      end
      cnt_r      <= cnt_nxt_s;
      data_ok_r  <= r_take_s;
      data_err_r <= r_take_s && rresp[1];
      if (r_take_s) begin
        rdata_r <= rdata;
      end
      if (proto_hit_s) begin
        proto_err_r <= 1'b1;
      end
    end
  end

  assign inst_addr_ok  = accept_s;
  assign inst_rdata    = rdata_r;
  assign inst_data_ok  = data_ok_r;
  assign inst_data_err = data_err_r;
  assign idle          = !arvalid_r && (cnt_r == 4'd0);
  assign arid          = ARID;
  assign araddr        = araddr_r;
  assign arlen         = 8'd0;
  assign arsize        = 3'b010;
  assign arburst       = 2'b01;
  assign arcache       = arcache_r;
  assign arvalid       = arvalid_r;
  assign rready        = !reset;
  assign proto_err     = proto_err_r;

endmodule

// File: tb/tb_inst_axi_responder.sv
// Directed self-checking bench for inst_axi_responder (MAX_OUTSTANDING = 4).
module tb_inst_axi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        inst_data_err;
  logic        idle;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        proto_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int n_ok;

  inst_axi_responder #(.MAX_OUTSTANDING(4), .ARID(4'd0)) dut (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_cache(inst_cache),
    .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata),
    .inst_data_ok(inst_data_ok), .inst_data_err(inst_data_err), .idle(idle),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    inst_req   = 1'b0;
    inst_cache = 1'b0;
    inst_addr  = 32'd0;
    arready    = 1'b0;
    rid        = 4'd0;
    rdata      = 32'd0;
    rresp      = 2'b00;
    rlast      = 1'b1;
    rvalid     = 1'b0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    quiet_inputs();
    reset = 1'b1;
    step();
    #1;
    check_eq("rst_rready", 32'(rready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_eq("rst_arvalid", 32'(arvalid), 32'd0);
    check_eq("rst_araddr", araddr, 32'd0);
    check_eq("rst_arcache", 32'(arcache), 32'd0);
    check_eq("rst_data_ok", 32'(inst_data_ok), 32'd0);
    check_eq("rst_rdata", inst_rdata, 32'd0);
    check_eq("rst_data_err", 32'(inst_data_err), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd1);
    check_eq("rst_rready_rel", 32'(rready), 32'd1);

    // Single fetch with minimum latency.
    inst_req  = 1'b1;
    inst_addr = 32'h1FC0_0000;
    arready   = 1'b1;
    #1;
    check_eq("s_addr_ok", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0;
    #1;
    check_eq("s_arvalid", 32'(arvalid), 32'd1);
    check_eq("s_araddr", araddr, 32'h1FC0_0000);
    check_eq("s_arcache", 32'(arcache), 32'd0);
    check_eq("s_arlen", 32'(arlen), 32'd0);
    check_eq("s_arsize", 32'(arsize), 32'd2);
    check_eq("s_arburst", 32'(arburst), 32'd1);
    check_eq("s_arid", 32'(arid), 32'd0);
    check_eq("s_idle_busy", 32'(idle), 32'd0);
    step();
    check_eq("s_arvalid_drop", 32'(arvalid), 32'd0);
    rvalid = 1'b1;
    rdata  = 32'h3C1D_8000;
    step();
    rvalid = 1'b0;
    check_eq("s_data_ok", 32'(inst_data_ok), 32'd1);
    check_eq("s_rdata", inst_rdata, 32'h3C1D_8000);
    check_eq("s_data_err", 32'(inst_data_err), 32'd0);
    check_eq("s_idle_back", 32'(idle), 32'd1);
    step();
    check_eq("s_data_ok_pulse", 32'(inst_data_ok), 32'd0);

    // AR back-pressure: address held stable, no further accepts.
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    #1;
    check_eq("bp_accept", 32'(inst_addr_ok), 32'd1);
    step();
    n_ok = 0;
    inst_addr = 32'h0000_0104;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (inst_addr_ok) n_ok++;
      check_eq("bp_araddr", araddr, 32'h0000_0100);
      step();
    end
    check_eq("bp_extra_ok", 32'(n_ok), 32'd0);
    arready = 1'b1;
    #1;
    check_eq("bp_slot_free", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0;
    check_eq("bp_reload", araddr, 32'h0000_0104);
    check_eq("bp_reload_v", 32'(arvalid), 32'd1);

    // Outstanding limit of four, and same-cycle reassert on an R beat.
    do_reset();
    arready = 1'b1;
    n_ok = 0;
    for (int i = 0; i < 6; i++) begin
      inst_req  = 1'b1;
      inst_addr = 32'(i * 4);
      #1;
      if (inst_addr_ok) n_ok++;
      step();
    end
    check_eq("lim_count", 32'(n_ok), 32'd4);
    #1;
    check_eq("lim_full", 32'(inst_addr_ok), 32'd0);
    rvalid = 1'b1;
    rdata  = 32'hAAAA_0000;
    #1;
    check_eq("lim_r_frees", 32'(inst_addr_ok), 32'd1);
    step();
    inst_req = 1'b0;
    rvalid   = 1'b0;
    check_eq("lim_data_ok", 32'(inst_data_ok), 32'd1);
    check_eq("lim_rdata", inst_rdata, 32'hAAAA_0000);
    check_eq("lim_not_idle", 32'(idle), 32'd0);

    // In-order back-to-back stream, cacheable fetches.
    do_reset();
    arready    = 1'b1;
    inst_cache = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_req  = 1'b1;
      inst_addr = 32'(i * 4);
      step();
      if (i == 0) check_eq("ord_arcache", 32'(arcache), 32'hF);
    end
    inst_req = 1'b0;
    step();
    check_eq("ord_pending", 32'(idle), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = 32'(i * 4);
      step();
      check_eq("ord_data_ok", 32'(inst_data_ok), 32'd1);
      check_eq("ord_rdata", inst_rdata, 32'(i * 4));
    end
    rvalid = 1'b0;
    step();
    check_eq("ord_done_ok", 32'(inst_data_ok), 32'd0);
    check_eq("ord_idle", 32'(idle), 32'd1);
    check_eq("ord_no_proto", 32'(proto_err), 32'd0);

    // SLVERR response, then a stray beat with nothing outstanding.
    do_reset();
    arready   = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0200;
    step();
    inst_req = 1'b0;
    step();
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    rresp  = 2'b10;
    step();
    rvalid = 1'b0;
    rresp  = 2'b00;
    check_eq("err_data_ok", 32'(inst_data_ok), 32'd1);
    check_eq("err_flag", 32'(inst_data_err), 32'd1);
    check_eq("err_rdata", inst_rdata, 32'hDEAD_BEEF);
    check_eq("err_no_proto", 32'(proto_err), 32'd0);
    rvalid = 1'b1;
    rdata  = 32'h1234_5678;
    step();
    rvalid = 1'b0;
    check_eq("stray_dropped", 32'(inst_data_ok), 32'd0);
    check_eq("stray_proto", 32'(proto_err), 32'd1);
    step();
    step();
    check_eq("stray_sticky", 32'(proto_err), 32'd1);

    // Beat with rlast=0 is returned but flagged.
    do_reset();
    check_eq("proto_cleared", 32'(proto_err), 32'd0);
    arready   = 1'b1;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0300;
    step();
    inst_req = 1'b0;
    step();
    rvalid = 1'b1;
    rdata  = 32'h0BAD_F00D;
    rlast  = 1'b0;
    step();
    rvalid = 1'b0;
    rlast  = 1'b1;
    check_eq("nolast_data_ok", 32'(inst_data_ok), 32'd1);
    check_eq("nolast_rdata", inst_rdata, 32'h0BAD_F00D);
    check_eq("nolast_proto", 32'(proto_err), 32'd1);

    // Reset with three outstanding and an AR still pending.
    do_reset();
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_req  = 1'b1;
      inst_addr = 32'h0000_1000 + 32'(i * 4);
      step();
    end
    inst_req = 1'b0;
    arready  = 1'b0;
    #1;
    check_eq("mid_arvalid", 32'(arvalid), 32'd1);
    check_eq("mid_busy", 32'(idle), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("mid_rready", 32'(rready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check_eq("mid_rst_araddr", araddr, 32'd0);
    check_eq("mid_rst_idle", 32'(idle), 32'd1);
    check_eq("mid_rst_data_ok", 32'(inst_data_ok), 32'd0);
    check_eq("mid_rst_rdata", inst_rdata, 32'd0);
    rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check_eq("mid_late_beat_ok", 32'(inst_data_ok), 32'd0);
    check_eq("mid_late_beat_proto", 32'(proto_err), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/inst_axi_responder.md
Name: inst_axi_responder

Overview:
- Responder for the SRAM-like instruction fetch interface (inst_req / inst_addr_ok / inst_data_ok) driven by the fetch stage.
- Accepts fetch requests and converts each one to a single-beat AXI4 read.
- Returns read data to the fetch stage strictly in request order.
- Tracks outstanding requests, so data for cancelled fetches is still returned; the requester must always drain responses.

Parameters:
MAX_OUTSTANDING, 4, max accepted-but-unanswered requests (1..15)
ARID, 4'd0, constant AXI read ID for all fetches

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
inst_req  in  1  fetch request valid
inst_cache  in  1  1 = cacheable attribute
inst_addr  in  32  physical fetch address
inst_addr_ok  out  1  request accepted this cycle
inst_rdata  out  32  returned instruction word
inst_data_ok  out  1  inst_rdata valid, one-cycle pulse
inst_data_err  out  1  qualifies inst_data_ok: AXI returned SLVERR/DECERR
idle  out  1  no AR pending and zero outstanding
arid  out  4  =ARID
araddr  out  32  read address
arlen  out  8  constant 0
arsize  out  3  constant 3'b010
arburst  out  2  constant 2'b01
arcache  out  4  4'b1111 if cached else 4'b0000
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  ignored (single ID, in order)
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  must be 1; checked
rvalid  in  1  R valid
rready  out  1  constant 1 except during reset
proto_err  out  1  sticky: R beat with outstanding==0, or rlast==0

Behaviour:
- Reset (reset=1 at a clock edge): arvalid=0, araddr=0, arcache=0, inst_data_ok=0, inst_rdata=0, inst_data_err=0, proto_err=0, outstanding count cnt=0; rready=0 while reset=1.
- AR slot free: arvalid==0, or arvalid && arready.
- inst_addr_ok is combinational: inst_req && slot free && (cnt < MAX_OUTSTANDING, or an R beat is consumed this cycle). It never depends on inst_data_ok.
- On accept: next cycle arvalid=1, araddr=inst_addr, arcache from inst_cache.
- AR holds its value stable until arready. An AR handshake and a new accept in the same cycle reload the register (back-to-back issue, one AR per cycle).
- cnt (4-bit):
  - +1 on accept; -1 on an R handshake while cnt>0.
  - Both in the same cycle: cnt unchanged.
  - cnt never exceeds MAX_OUTSTANDING and never underflows.
- R channel:
  - On rvalid && rready with cnt>0: next cycle inst_data_ok=1, inst_rdata=rdata, inst_data_err=(rresp[1]==1).
  - inst_data_ok is a single-cycle pulse per beat. Back-to-back beats give consecutive pulses.
  - No back-pressure toward AXI or from the requester.
- Protocol errors: an R beat with cnt==0 is dropped (no data_ok) and sets proto_err. An R beat with rlast==0 also sets proto_err but is still returned. proto_err clears only on reset.
- Minimum latency: accept at cycle T; arvalid at T+1; arready at T+1 and rvalid at T+2 gives inst_data_ok at T+3.
- Ordering: responses return in AR issue order (single ID).
- idle = !arvalid && cnt==0. This is used before cache-op and TLB-flush sequencing.
- Reset mid-operation: all tracking is discarded. The AXI fabric must be reset in the same cycle. R beats arriving after reset with cnt==0 set proto_err.

Test Plan:
- Single fetch: inst_req with addr 0x1FC00000, cache=0; arready=1; rvalid with rdata 0x3C1D8000 two cycles later → addr_ok at T, arvalid/araddr=0x1FC00000/arcache=0 at T+1, data_ok pulse with rdata 0x3C1D8000 at T+3, idle returns 1.
- Back-pressure: hold arready=0 for 5 cycles with inst_req held → araddr stable, exactly one addr_ok until slot frees, cnt=1.
- Outstanding limit: MAX_OUTSTANDING=4, arready=1, no R beats, 6 requests → exactly 4 addr_ok, then addr_ok=0. One R beat → addr_ok reasserts in that same cycle.
- Order and stream: 4 requests at 0x00000000/04/08/0C, R beats back-to-back with rdata=addr → 4 consecutive data_ok pulses returning 0x0, 0x4, 0x8, 0xC.
- Errors: rresp=2'b10 → data_ok with inst_data_err=1. R beat with cnt=0 → no data_ok, proto_err=1 until reset.
- Reset with cnt=3 and arvalid=1 → next cycle arvalid=0, cnt=0, idle=1, all outputs at reset values.
